// File: rtl/plab3_mem_blocking_l2_refill_responder.sv
// Blocking cacheline memory responder for the memory side of the L2.
// One transaction in flight; responses return after a fixed latency.
// Every stored line carries an owner-domain tag. Reads from another domain
// see zeros, and a write from a new owner wipes the bytes it does not write.
module plab3_mem_blocking_l2_refill_responder #(
   parameter  int p_opaque_nbits = 8,
   parameter  int abw            = 32,
   parameter  int clw            = 128,
   parameter  int p_nlines       = 64,
   parameter  int p_latency      = 2,
   localparam int idw            = $clog2(p_nlines),
   localparam int lenw           = $clog2(clw/8),
   localparam int tw             = 3,
   localparam int reqw           = tw + p_opaque_nbits + abw + lenw + clw,
   localparam int respw          = tw + p_opaque_nbits + lenw + clw
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             domain,
   input  logic             memreq_val,
   output logic             memreq_rdy,
   input  logic [reqw-1:0]  memreq_msg,
   output logic             memresp_val,
   input  logic             memresp_rdy,
   output logic [respw-1:0] memresp_msg,
   output logic             busy
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                    r_state;
   logic [3:0]                r_cnt;
   logic [tw-1:0]             r_type;
   logic [p_opaque_nbits-1:0] r_opaque;
   logic [abw-1:0]            r_addr;
   logic [lenw-1:0]           r_len;
   logic [clw-1:0]            r_data;
   logic                      r_req_dom;
   logic                      r_memreq_rdy;
   logic                      r_memresp_val;
   logic [respw-1:0]          r_memresp_msg;
   logic                      r_busy;

   logic [clw-1:0]            r_line [p_nlines];
   logic [p_nlines-1:0]       r_tag;

   // request fields, MSB first: type, opaque, addr, len, data
   logic [clw-1:0]            w_in_data;
   logic [lenw-1:0]           w_in_len;
   logic [abw-1:0]            w_in_addr;
   logic [p_opaque_nbits-1:0] w_in_opaque;
   logic [tw-1:0]             w_in_type;

   assign w_in_data   = memreq_msg[clw-1:0];
   assign w_in_len    = memreq_msg[clw +: lenw];
   assign w_in_addr   = memreq_msg[clw+lenw +: abw];
   assign w_in_opaque = memreq_msg[clw+lenw+abw +: p_opaque_nbits];
   assign w_in_type   = memreq_msg[clw+lenw+abw+p_opaque_nbits +: tw];

   logic w_accept, w_dom_ok, w_enter_resp;

   assign w_accept     = (r_state == S_IDLE) && memreq_val && r_memreq_rdy;
   assign w_dom_ok     = (domain == r_req_dom);
   // With zero latency the array is accessed on the accept edge itself.
   assign w_enter_resp = (w_accept && (p_latency == 0)) ||
                         ((r_state == S_WAIT) && w_dom_ok && (r_cnt == 4'd1));

   // When entering RESP straight from IDLE the latches are not loaded yet,
   // so the array access takes the fields directly from the request.
   logic                      w_src_idle;
   logic [tw-1:0]             w_c_type;
   logic [p_opaque_nbits-1:0] w_c_opaque;
   logic [abw-1:0]            w_c_addr;
   logic [lenw-1:0]           w_c_len;
   logic [clw-1:0]            w_c_data;
   logic                      w_c_dom;

   assign w_src_idle = (r_state == S_IDLE);
   assign w_c_type   = w_src_idle ? w_in_type   : r_type;
   assign w_c_opaque = w_src_idle ? w_in_opaque : r_opaque;
   assign w_c_addr   = w_src_idle ? w_in_addr   : r_addr;
   assign w_c_len    = w_src_idle ? w_in_len    : r_len;
   assign w_c_data   = w_src_idle ? w_in_data   : r_data;
   assign w_c_dom    = w_src_idle ? domain      : r_req_dom;

   // byte offset bits within the line play no part in addressing
   logic w_unused_ok;
   assign w_unused_ok = &{1'b0, w_c_addr[3:0]};

   logic [idw-1:0]   w_idx;
   logic             w_oor;
   logic             w_is_wr;
   logic [clw-1:0]   w_mask;
   logic [clw-1:0]   w_owned;
   logic [clw-1:0]   w_wr_line;
   logic [clw-1:0]   w_rd_data;
   logic [respw-1:0] w_resp;
   logic             w_commit_wr;

   assign w_idx   = w_c_addr[4 +: idw];
   assign w_oor   = (w_c_addr >> (4 + idw)) != '0;
   assign w_is_wr = (w_c_type == tw'(1));

   // Byte enables: len 0 means the whole line, otherwise bytes 0..len-1.
   always_comb begin
      w_mask = '0;
      for (int b = 0; b < clw/8; b++)
         if ((w_c_len == '0) || (lenw'(b) < w_c_len)) w_mask[b*8 +: 8] = 8'hFF;
   end

   // A line is only visible to its owner; otherwise it reads as zero, which
   // also yields the zero-fill of unwritten bytes when ownership changes.
   assign w_owned     = (r_tag[w_idx] == w_c_dom) ? r_line[w_idx] : '0;
   assign w_wr_line   = (w_owned & ~w_mask) | (w_c_data & w_mask);
   assign w_rd_data   = (w_is_wr || w_oor) ? '0 : w_owned;
   assign w_resp      = {w_c_type, w_c_opaque, {lenw{1'b0}}, w_rd_data};
   assign w_commit_wr = w_enter_resp && w_is_wr && !w_oor;

   // Line storage and owner tags; writes commit on the edge into RESP.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < p_nlines; i++) r_line[i] <= '0;
         r_tag <= '0;
      end else if (w_commit_wr) begin
         r_line[w_idx] <= w_wr_line;
         r_tag[w_idx]  <= w_c_dom;
      end
   end

   // Control FSM with registered handshake outputs and response message.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_type        <= '0;
         r_opaque      <= '0;
         r_addr        <= '0;
         r_len         <= '0;
         r_data        <= '0;
         r_req_dom     <= 1'b0;
         r_memreq_rdy  <= 1'b0;
         r_memresp_val <= 1'b0;
         r_memresp_msg <= '0;
         r_busy        <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_memreq_rdy <= 1'b1;
               if (w_accept) begin
                  r_type       <= w_in_type;
                  r_opaque     <= w_in_opaque;
                  r_addr       <= w_in_addr;
                  r_len        <= w_in_len;
                  r_data       <= w_in_data;
                  r_req_dom    <= domain;
                  r_cnt        <= 4'(p_latency);
                  r_memreq_rdy <= 1'b0;
                  r_busy       <= 1'b1;
                  if (p_latency == 0) begin
                     r_state       <= S_RESP;
                     r_memresp_val <= 1'b1;
                     r_memresp_msg <= w_resp;
                  end else begin
                     r_state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (!w_dom_ok) begin
                  // domain switched under us: drop the transaction silently
                  r_state      <= S_IDLE;
                  r_busy       <= 1'b0;
                  r_memreq_rdy <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
                  if (r_cnt == 4'd1) begin
                     r_state       <= S_RESP;
                     r_memresp_val <= 1'b1;
                     r_memresp_msg <= w_resp;
                  end
               end
            end
            S_RESP: begin
               if (!w_dom_ok || memresp_rdy) begin
                  r_state       <= S_IDLE;
                  r_busy        <= 1'b0;
                  r_memreq_rdy  <= 1'b1;
                  r_memresp_val <= 1'b0;
                  r_memresp_msg <= '0;
               end
            end
            default: begin
               r_state       <= S_IDLE;
               r_busy        <= 1'b0;
               r_memresp_val <= 1'b0;
               r_memresp_msg <= '0;
            end
         endcase
      end
   end

   assign memreq_rdy  = r_memreq_rdy;
   assign memresp_val = r_memresp_val;
   assign memresp_msg = r_memresp_msg;
   assign busy        = r_busy;

endmodule

// File: tb/tb_plab3_mem_blocking_l2_refill_responder.sv
// Bench for the blocking L2 refill responder: a byte-level line/owner model
// feeds an expected-response queue that each scenario drains and checks.
module tb_plab3_mem_blocking_l2_refill_responder;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         domain = 1'b0;
   logic         memreq_val = 1'b0;
   logic         memreq_rdy;
   logic [174:0] memreq_msg = '0;
   logic         memresp_val;
   logic         memresp_rdy = 1'b1;
   logic [142:0] memresp_msg;
   logic         busy;

   int n_cmp = 0;
   int n_bad = 0;

   logic [142:0] exp_q[$];
   logic [127:0] m_line[64];
   bit           m_tag[64];

   localparam logic [127:0] D1 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
   localparam logic [127:0] D2 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   plab3_mem_blocking_l2_refill_responder dut (
      .clk         (clk),
      .reset       (reset),
      .domain      (domain),
      .memreq_val  (memreq_val),
      .memreq_rdy  (memreq_rdy),
      .memreq_msg  (memreq_msg),
      .memresp_val (memresp_val),
      .memresp_rdy (memresp_rdy),
      .memresp_msg (memresp_msg),
      .busy        (busy)
   );

   function automatic void model_clear();
      for (int i = 0; i < 64; i++) begin
         m_line[i] = '0;
         m_tag[i]  = 1'b0;
      end
   endfunction

   // Applies a request to the model and returns the response it should get.
   function automatic logic [142:0] model(input logic [2:0] t, input logic [7:0] op,
                                          input logic [31:0] a, input logic [3:0] l,
                                          input logic [127:0] d, input bit dm);
      int           idx;
      bit           oor;
      logic [127:0] rd;
      idx = int'(a[9:4]);
      oor = (a[31:10] != 22'd0);
      rd  = '0;
      if (t == 3'd1) begin
         if (!oor) begin
            if (m_tag[idx] != dm) m_line[idx] = '0;
            for (int b = 0; b < 16; b++)
               if (l == 4'd0 || b < int'(l)) m_line[idx][b*8 +: 8] = d[b*8 +: 8];
            m_tag[idx] = dm;
         end
      end else if (!oor && m_tag[idx] == dm) begin
         rd = m_line[idx];
      end
      return {t, op, 4'd0, rd};
   endfunction

   // Issues one request; returns at the falling edge after the accept edge.
   task automatic send(input logic [2:0] t, input logic [7:0] op, input logic [31:0] a,
                       input logic [3:0] l, input logic [127:0] d, input bit dm,
                       input bit push, output bit ok);
      int n;
      n  = 0;
      ok = 1'b0;
      @(negedge clk);
      while (!memreq_rdy && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (memreq_rdy) begin
         domain     = dm;
         memreq_msg = {t, op, a, l, d};
         memreq_val = 1'b1;
         if (push) exp_q.push_back(model(t, op, a, l, d, dm));
         @(posedge clk);
         ok = 1'b1;
         @(negedge clk);
         memreq_val = 1'b0;
         memreq_msg = '0;
      end
   endtask

   // Waits for a response; lat counts cycles from the accept edge (first
   // falling edge after it is cycle 1). Completes the handshake.
   task automatic recv(output logic [142:0] msg, output int lat, output bit got);
      lat = 1;
      got = 1'b0;
      msg = '0;
      while (!memresp_val && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (memresp_val) begin
         got = 1'b1;
         msg = memresp_msg;
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic xact(input logic [2:0] t, input logic [7:0] op, input logic [31:0] a,
                       input logic [3:0] l, input logic [127:0] d, input bit dm,
                       output bit got, output logic [142:0] msg,
                       output logic [142:0] exp, output int lat);
      bit ok;
      send(t, op, a, l, d, dm, 1'b1, ok);
      recv(msg, lat, got);
      got = got & ok;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
   endtask

   task automatic test_reset();
      model_clear();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (memreq_rdy !== 1'b0 || memresp_val !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_ctrl: rdy=%b val=%b busy=%b want 0 0 0", memreq_rdy, memresp_val, busy);
      end
      n_cmp++;
      if (memresp_msg !== '0) begin
         n_bad++;
         $display("FAIL reset_msg: got %h want 0", memresp_msg);
      end
      reset = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (memreq_rdy !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_release_rdy: got %b want 1", memreq_rdy);
      end
   endtask

   task automatic test_write_read();
      bit ok, got;
      logic [142:0] msg, exp;
      int lat;
      send(3'd1, 8'h11, 32'h100, 4'd0, D1, 1'b0, 1'b1, ok);
      n_cmp++;
      if (!ok || busy !== 1'b1 || memreq_rdy !== 1'b0) begin
         n_bad++;
         $display("FAIL wr_in_flight: ok=%b busy=%b rdy=%b want 1 1 0", ok, busy, memreq_rdy);
      end
      recv(msg, lat, got);
      exp = exp_q.pop_front();
      n_cmp++;
      if (!got || msg !== exp || msg !== {3'd1, 8'h11, 4'd0, 128'd0}) begin
         n_bad++;
         $display("FAIL wr_resp: got %h want %h", msg, exp);
      end
      n_cmp++;
      if (lat != 3) begin
         n_bad++;
         $display("FAIL wr_latency: got %0d want 3", lat);
      end
      xact(3'd0, 8'h12, 32'h100, 4'd0, '0, 1'b0, got, msg, exp, lat);
      n_cmp++;
      if (!got || msg !== exp || msg[127:0] !== D1) begin
         n_bad++;
         $display("FAIL rd_0x100: got %h want %h", msg, exp);
      end
      n_cmp++;
      if (lat != 3) begin
         n_bad++;
         $display("FAIL rd_latency: got %0d want 3", lat);
      end
      // AMO-type request behaves as a read and echoes its type
      xact(3'd3, 8'h13, 32'h104, 4'd0, 128'h5, 1'b0, got, msg, exp, lat);
      n_cmp++;
      if (!got || msg !== exp || msg[142:140] !== 3'd3) begin
         n_bad++;
         $display("FAIL amo_as_read: got %h want %h", msg, exp);
      end
   endtask

   task automatic test_domain_isolation();
      bit got;
      logic [142:0] msg, exp;
      int lat;
      xact(3'd1, 8'h20, 32'h200, 4'd0, D2, 1'b1, got, msg, exp, lat);
      n_cmp++;
      if (!got || msg !== exp) begin
         n_bad++;
         $display("FAIL iso_wr: got %h want %h", msg, exp);
      end
      xact(3'd0, 8'h21, 32'h200, 4'd0, '0, 1'b0, got, msg, exp, lat);
      n_cmp++;
      if (!got || msg !== exp || msg[127:0] !== 128'd0) begin
         n_bad++;
         $display("FAIL iso_foreign_rd: got %h want %h", msg, exp);
      end
      xact(3'd0, 8'h22, 32'h200, 4'd0, '0, 1'b1, got, msg, exp, lat);
      n_cmp++;
      if (!got || msg !== exp || msg[127:0] !== D2) begin
         n_bad++;
         $display("FAIL iso_owner_rd: got %h want %h", msg, exp);
      end
   endtask

   task automatic test_partial_write();
      bit got;
      logic [142:0] msg, exp;
      int lat;
      logic [127:0] pd;
      pd = {96'hAAAAAAAA_BBBBBBBB_CCCCCCCC, 32'h11223344};
      xact(3'd1, 8'h30, 32'h180, 4'd0, '1, 1'b0, got, msg, exp, lat);
      xact(3'd1, 8'h31, 32'h180, 4'd4, pd, 1'b0, got, msg, exp, lat);
      n_cmp++;
      if (!got || msg !== exp) begin
         n_bad++;
         $display("FAIL part_wr_resp: got %h want %h", msg, exp);
      end
      xact(3'd0, 8'h32, 32'h180, 4'd0, '0, 1'b0, got, msg, exp, lat);
      n_cmp++;
      if (!got || msg !== exp || msg[127:0] !== {96'hFFFFFFFF_FFFFFFFF_FFFFFFFF, 32'h11223344}) begin
         n_bad++;
         $display("FAIL part_same_dom: got %h want %h", msg, exp);
      end
      xact(3'd1, 8'h33, 32'h180, 4'd4, pd, 1'b1, got, msg, exp, lat);
      xact(3'd0, 8'h34, 32'h180, 4'd0, '0, 1'b1, got, msg, exp, lat);
      n_cmp++;
      if (!got || msg !== exp || msg[127:0] !== {96'd0, 32'h11223344}) begin
         n_bad++;
         $display("FAIL part_new_owner: got %h want %h", msg, exp);
      end
   endtask

   task automatic test_backpressure();
      bit ok, stable;
      logic [142:0] msg, exp;
      int n;
      memresp_rdy = 1'b0;
      send(3'd0, 8'h40, 32'h100, 4'd0, '0, 1'b0, 1'b1, ok);
      n = 0;
      while (!memresp_val && n < 40) begin
         @(negedge clk);
         n++;
      end
      msg = memresp_msg;
      exp = exp_q.pop_front();
      n_cmp++;
      if (!ok || memresp_val !== 1'b1 || msg !== exp) begin
         n_bad++;
         $display("FAIL bp_resp: val=%b got %h want %h", memresp_val, msg, exp);
      end
      stable = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (memresp_val !== 1'b1 || memresp_msg !== msg || memreq_rdy !== 1'b0) stable = 1'b0;
      end
      n_cmp++;
      if (!stable) begin
         n_bad++;
         $display("FAIL bp_hold: got unstable want stable val/msg with rdy=0");
      end
      memresp_rdy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (memreq_rdy !== 1'b1 || memresp_val !== 1'b0 || memresp_msg !== '0) begin
         n_bad++;
         $display("FAIL bp_release: rdy=%b val=%b msg=%h want 1 0 0", memreq_rdy, memresp_val, memresp_msg);
      end
   endtask

   task automatic test_domain_abort();
      bit ok, got, seen;
      logic [142:0] msg, exp;
      int lat;
      send(3'd1, 8'h50, 32'h300, 4'd0, D1, 1'b0, 1'b0, ok);
      domain = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (memresp_val !== 1'b0) seen = 1'b1;
      end
      n_cmp++;
      if (!ok || seen) begin
         n_bad++;
         $display("FAIL abort_no_resp: ok=%b seen=%b want 1 0", ok, seen);
      end
      n_cmp++;
      if (busy !== 1'b0 || memreq_rdy !== 1'b1) begin
         n_bad++;
         $display("FAIL abort_idle: busy=%b rdy=%b want 0 1", busy, memreq_rdy);
      end
      xact(3'd0, 8'h51, 32'h300, 4'd0, '0, 1'b0, got, msg, exp, lat);
      n_cmp++;
      if (!got || msg !== exp || msg[127:0] !== 128'd0) begin
         n_bad++;
         $display("FAIL abort_no_commit: got %h want %h", msg, exp);
      end
   endtask

   task automatic test_out_of_range();
      bit got;
      logic [142:0] msg, exp;
      int lat;
      xact(3'd0, 8'h5A, 32'h8000_0000, 4'd0, '0, 1'b0, got, msg, exp, lat);
      n_cmp++;
      if (!got || msg !== exp || msg !== {3'd0, 8'h5A, 4'd0, 128'd0}) begin
         n_bad++;
         $display("FAIL oor_rd: got %h want %h", msg, exp);
      end
      xact(3'd1, 8'h5B, 32'h8000_0100, 4'd0, D2, 1'b0, got, msg, exp, lat);
      n_cmp++;
      if (!got || msg !== exp) begin
         n_bad++;
         $display("FAIL oor_wr_resp: got %h want %h", msg, exp);
      end
      xact(3'd0, 8'h5C, 32'h100, 4'd0, '0, 1'b0, got, msg, exp, lat);
      n_cmp++;
      if (!got || msg !== exp || msg[127:0] !== D1) begin
         n_bad++;
         $display("FAIL oor_wr_dropped: got %h want %h", msg, exp);
      end
   endtask

   task automatic test_reset_mid_wait();
      bit ok, got, bad;
      logic [142:0] msg, exp;
      int lat;
      send(3'd0, 8'h60, 32'h100, 4'd0, '0, 1'b0, 1'b0, ok);
      reset = 1'b0;
      bad = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (memresp_val !== 1'b0 || memreq_rdy !== 1'b0) bad = 1'b1;
      end
      n_cmp++;
      if (!ok || bad) begin
         n_bad++;
         $display("FAIL rst_mid_wait: ok=%b bad=%b want 1 0", ok, bad);
      end
      reset = 1'b1;
      model_clear();
      @(negedge clk);
      n_cmp++;
      if (memreq_rdy !== 1'b1 || memresp_val !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_release: rdy=%b val=%b want 1 0", memreq_rdy, memresp_val);
      end
      xact(3'd0, 8'h61, 32'h100, 4'd0, '0, 1'b0, got, msg, exp, lat);
      n_cmp++;
      if (!got || msg !== exp || msg[127:0] !== 128'd0) begin
         n_bad++;
         $display("FAIL rst_cleared_0x100: got %h want %h", msg, exp);
      end
      xact(3'd0, 8'h62, 32'h200, 4'd0, '0, 1'b1, got, msg, exp, lat);
      n_cmp++;
      if (!got || msg !== exp || msg[127:0] !== 128'd0) begin
         n_bad++;
         $display("FAIL rst_cleared_0x200: got %h want %h", msg, exp);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_domain_isolation();
      test_partial_write();
      test_backpressure();
      test_domain_abort();
      test_out_of_range();
      test_reset_mid_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
